line_window_ctrl: RTL and testbench

- Parametrised successor to the 4-line-buffer image filter front end.
- Accepts a raster pixel stream into a ring of NUM_LINES line buffers, then emits one KERNEL_ROWS x KERNEL_ROWS pixel window per beat to the downstream filter core.
- Adds slave and master backpressure, generic kernel size and line count, and optional horizontal zero padding.
- Raises intr_out each time a line buffer is released, so the DMA or testbench can send the next row.

---
 rtl/line_window_ctrl.sv | 157 +++++++++++++++
 tb/tb_line_window_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_window_ctrl.sv
// Line-buffer ring that turns a raster pixel stream into KERNEL_ROWS x KERNEL_ROWS
// windows, with ready/valid on both sides and optional horizontal zero padding.
module line_window_ctrl #(
    parameter int IMAGE_WIDTH = 512,
    parameter int IW_BIT_NUM  = 9,
    parameter int PIXEL_WIDTH = 8,
    parameter int NUM_LINES   = 4,
    parameter int LB_BIT_NUM  = 2,
    parameter int KERNEL_ROWS = 3,
    parameter int PAD_MODE    = 0
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          s_data_valid,
    input  logic [PIXEL_WIDTH-1:0]                        s_data,
    output logic                                          s_data_ready,
    output logic                                          m_data_valid,
    output logic [KERNEL_ROWS*KERNEL_ROWS*PIXEL_WIDTH-1:0] m_data,
    input  logic                                          m_data_ready,
    output logic                                          intr_out,
    output logic [LB_BIT_NUM:0]                           fill_level
);

    localparam int NW    = (PAD_MODE != 0) ? IMAGE_WIDTH : IMAGE_WIDTH - KERNEL_ROWS + 1;
    localparam int OFF   = (PAD_MODE != 0) ? (KERNEL_ROWS - 1) / 2 : 0;
    localparam int WIN_W = KERNEL_ROWS * KERNEL_ROWS * PIXEL_WIDTH;

    localparam logic [LB_BIT_NUM:0]   FILL_FULL = (LB_BIT_NUM + 1)'(NUM_LINES);
    localparam logic [LB_BIT_NUM:0]   FILL_RUN  = (LB_BIT_NUM + 1)'(KERNEL_ROWS);
    localparam logic [IW_BIT_NUM-1:0] COL_LAST  = IW_BIT_NUM'(IMAGE_WIDTH - 1);
    localparam logic [IW_BIT_NUM:0]   RD_DONE   = (IW_BIT_NUM + 1)'(NW);
    localparam logic [LB_BIT_NUM-1:0] LINE_LAST = LB_BIT_NUM'(NUM_LINES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RELEASE
    } state_e;

    state_e state_q, state_d;

    logic [PIXEL_WIDTH-1:0] line_buf [NUM_LINES][IMAGE_WIDTH];

    logic [LB_BIT_NUM-1:0] wr_line_q, wr_line_d;
    logic [IW_BIT_NUM-1:0] wr_col_q, wr_col_d;
    logic [LB_BIT_NUM-1:0] rd_line_q, rd_line_d;
    logic [IW_BIT_NUM:0]   rd_col_q, rd_col_d;
    logic [LB_BIT_NUM:0]   fill_q, fill_d;
    logic                  mvalid_q, mvalid_d;
    logic [WIN_W-1:0]      mdata_q, mdata_d;
    logic [WIN_W-1:0]      window;

    logic wr_en, line_done, out_load, issue, release_now;

    assign s_data_ready = (fill_q < FILL_FULL);
    assign wr_en        = s_data_valid && s_data_ready;
    assign line_done    = wr_en && (wr_col_q == COL_LAST);
    assign out_load     = !mvalid_q || m_data_ready;
    assign issue        = (state_q == RUN) && (rd_col_q != RD_DONE) && out_load;
    assign release_now  = (state_q == RELEASE);

    assign m_data_valid = mvalid_q;
    assign m_data       = mdata_q;
    assign intr_out     = release_now;
    assign fill_level   = fill_q;

    always_ff @(posedge clk) begin
        if (wr_en) line_buf[wr_line_q][wr_col_q] <= s_data;
    end

    always_comb begin
        wr_col_d  = wr_col_q;
        wr_line_d = wr_line_q;
        if (wr_en) begin
            if (wr_col_q == COL_LAST) begin
                wr_col_d  = '0;
                wr_line_d = (wr_line_q == LINE_LAST) ? '0 : wr_line_q + 1'b1;
            end else begin
                wr_col_d = wr_col_q + 1'b1;
            end
        end
        // A completion and a release on the same edge cancel out.
        fill_d = fill_q;
        case ({line_done, release_now})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        rd_col_d  = rd_col_q;
        rd_line_d = rd_line_q;
        case (state_q)
            IDLE: begin
                if (fill_q >= FILL_RUN) state_d = RUN;
            end
            RUN: begin
                if (issue) rd_col_d = rd_col_q + 1'b1;
                // Leave only once the final window has actually been taken downstream.
                if ((rd_col_q == RD_DONE) && mvalid_q && m_data_ready) state_d = RELEASE;
            end
            RELEASE: begin
                state_d   = IDLE;
                rd_col_d  = '0;
                rd_line_d = (rd_line_q == LINE_LAST) ? '0 : rd_line_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        int li;
        int col;
        li     = 0;
        col    = 0;
        window = '0;
        for (int unsigned r = 0; r < KERNEL_ROWS; r++) begin
            li = (int'(rd_line_q) + int'(r)) % NUM_LINES;
            for (int unsigned c = 0; c < KERNEL_ROWS; c++) begin
                col = int'(rd_col_q) - OFF + int'(c);
                if (col >= 0 && col < IMAGE_WIDTH)
                    window[(r*KERNEL_ROWS+c)*PIXEL_WIDTH +: PIXEL_WIDTH] =
                        line_buf[LB_BIT_NUM'(li)][IW_BIT_NUM'(col)];
            end
        end
    end

    always_comb begin
        mvalid_d = out_load ? issue : mvalid_q;
        mdata_d  = issue ? window : mdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_line_q <= '0;
            wr_col_q  <= '0;
            rd_line_q <= '0;
            rd_col_q  <= '0;
            fill_q    <= '0;
            mvalid_q  <= 1'b0;
            mdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_line_q <= wr_line_d;
            wr_col_q  <= wr_col_d;
            rd_line_q <= rd_line_d;
            rd_col_q  <= rd_col_d;
            fill_q    <= fill_d;
            mvalid_q  <= mvalid_d;
            mdata_q   <= mdata_d;
        end
    end

endmodule

// File: tb/tb_line_window_ctrl.sv
// Self-checking bench for line_window_ctrl: two instances (valid-only and padded)
// checked against an image-array reference model.
module tb_line_window_ctrl;

    localparam int W  = 8;
    localparam int K  = 3;
    localparam int N  = 4;
    localparam int PW = 8;
    localparam int WW = K * K * PW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sel = 1'b0;
    logic          s_valid = 1'b0;
    logic [PW-1:0] s_data = '0;
    logic          m_ready = 1'b0;

    logic          s_ready0, s_ready1, mv0, mv1, intr0, intr1;
    logic [WW-1:0] md0, md1;
    logic [2:0]    fill0, fill1;

    logic          s_ready, mv, intr;
    logic [WW-1:0] md;
    logic [2:0]    fill;

    always #5 clk = ~clk;

    line_window_ctrl #(
        .IMAGE_WIDTH(W), .IW_BIT_NUM(3), .PIXEL_WIDTH(PW), .NUM_LINES(N),
        .LB_BIT_NUM(2), .KERNEL_ROWS(K), .PAD_MODE(0)
    ) dut0 (
        .clk(clk), .reset(reset), .s_data_valid(s_valid & ~sel), .s_data(s_data),
        .s_data_ready(s_ready0), .m_data_valid(mv0), .m_data(md0),
        .m_data_ready(m_ready & ~sel), .intr_out(intr0), .fill_level(fill0)
    );

    line_window_ctrl #(
        .IMAGE_WIDTH(W), .IW_BIT_NUM(3), .PIXEL_WIDTH(PW), .NUM_LINES(N),
        .LB_BIT_NUM(2), .KERNEL_ROWS(K), .PAD_MODE(1)
    ) dut1 (
        .clk(clk), .reset(reset), .s_data_valid(s_valid & sel), .s_data(s_data),
        .s_data_ready(s_ready1), .m_data_valid(mv1), .m_data(md1),
        .m_data_ready(m_ready & sel), .intr_out(intr1), .fill_level(fill1)
    );

    assign s_ready = sel ? s_ready1 : s_ready0;
    assign mv      = sel ? mv1 : mv0;
    assign md      = sel ? md1 : md0;
    assign intr    = sel ? intr1 : intr0;
    assign fill    = sel ? fill1 : fill0;

    int checks = 0;
    int errors = 0;

    // Reference model state: pixels still to send, image as received, window cursor.
    int pix_q[$];
    int img[16][W];
    int in_row, in_col;
    int nw, off;
    int win_rb, win_k, win_cnt, intr_cnt;

    logic          o_acc_in, o_wacc, o_mvalid, o_intr, o_sready;
    logic [WW-1:0] o_mdata;
    logic [2:0]    o_fill;

    function automatic logic [WW-1:0] exp_win(input int rb, input int k);
        logic [WW-1:0] w;
        int col;
        w = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) begin
                col = k - off + c;
                if (col >= 0 && col < W) w[(r*K+c)*PW +: PW] = 8'(img[rb+r][col]);
            end
        return w;
    endfunction

    task automatic adv_win(output bit last);
        last = 1'b0;
        win_cnt++;
        win_k++;
        if (win_k == nw) begin
            win_k = 0;
            win_rb++;
            last = 1'b1;
        end
    endtask

    task automatic model_clear();
        pix_q.delete();
        in_row = 0; in_col = 0;
        win_rb = 0; win_k = 0; win_cnt = 0; intr_cnt = 0;
        nw  = sel ? W : W - K + 1;
        off = sel ? (K - 1) / 2 : 0;
    endtask

    task automatic apply_reset(input bit pad);
        @(negedge clk);
        sel = pad; reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic push_pattern(input int rows);
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < W; c++) pix_q.push_back(r * 16 + c);
    endtask

    // One clock: drive at negedge, sample just after, update the model.
    task automatic tick(input bit mr, input bit sv_en);
        @(negedge clk);
        s_valid = sv_en && (pix_q.size() > 0);
        if (s_valid) s_data = 8'(pix_q[0]);
        m_ready = mr;
        #1;
        o_sready = s_ready; o_mvalid = mv; o_mdata = md; o_intr = intr; o_fill = fill;
        o_acc_in = s_valid && s_ready;
        o_wacc   = mv && mr;
        if (o_acc_in) begin
            void'(pix_q.pop_front());
            if (in_row < 16) img[in_row][in_col] = int'(s_data);
            in_col++;
            if (in_col == W) begin in_col = 0; in_row++; end
        end
        if (o_intr) intr_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1; sel = 1'b0; s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            checks += 5;
            if (mv !== 1'b0)    begin errors++; $display("FAIL reset_mvalid got %b want 0", mv); end
            if (md !== '0)      begin errors++; $display("FAIL reset_mdata got %h want 0", md); end
            if (intr !== 1'b0)  begin errors++; $display("FAIL reset_intr got %b want 0", intr); end
            if (fill !== 3'd0)  begin errors++; $display("FAIL reset_fill got %0d want 0", fill); end
            if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_sready got %b want 1", s_ready); end
        end
        @(negedge clk);
        reset = 1'b0; s_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (fill !== 3'd0) begin errors++; $display("FAIL post_reset_fill got %0d want 0", fill); end
    endtask

    task automatic test_basic();
        int intr_t, last_t, fill_at, fill_after;
        bit last;
        apply_reset(1'b0);
        push_pattern(3);
        intr_t = -1; last_t = -1; fill_at = -1; fill_after = -1;
        for (int t = 0; t < 60; t++) begin
            tick(1'b1, 1'b1);
            if (o_intr && intr_t < 0) begin intr_t = t; fill_at = int'(o_fill); end
            if (intr_t >= 0 && t == intr_t + 1) fill_after = int'(o_fill);
            if (o_wacc) begin
                checks++;
                if (o_mdata !== exp_win(win_rb, win_k)) begin
                    errors++; $display("FAIL basic_win k%0d got %h want %h", win_k, o_mdata, exp_win(win_rb, win_k));
                end
                if (win_k == 0 || win_k == 5) begin
                    checks++;
                    for (int r = 0; r < K; r++)
                        for (int c = 0; c < K; c++)
                            if (o_mdata[(r*K+c)*PW +: PW] !== 8'(r * 16 + c + win_k)) begin
                                errors++;
                                $display("FAIL basic_px k%0d r%0d c%0d got %h want %h", win_k, r, c,
                                         o_mdata[(r*K+c)*PW +: PW], 8'(r * 16 + c + win_k));
                            end
                end
                adv_win(last);
                if (last) last_t = t;
            end
        end
        checks += 5;
        if (win_cnt != 6)       begin errors++; $display("FAIL basic_count got %0d want 6", win_cnt); end
        if (intr_cnt != 1)      begin errors++; $display("FAIL basic_intr_count got %0d want 1", intr_cnt); end
        if (intr_t != last_t + 1) begin errors++; $display("FAIL basic_intr_time got %0d want %0d", intr_t, last_t + 1); end
        if (fill_at != 3)       begin errors++; $display("FAIL basic_fill_at_release got %0d want 3", fill_at); end
        if (fill_after != 2)    begin errors++; $display("FAIL basic_fill_after got %0d want 2", fill_after); end
    endtask

    task automatic test_backpressure();
        logic [WW-1:0] held;
        bit last, seen_intr, chk_sready;
        int t;
        apply_reset(1'b0);
        push_pattern(4);
        t = 0;
        while (pix_q.size() > 0 && t < 100) begin tick(1'b0, 1'b1); t++; end
        tick(1'b0, 1'b1);
        checks += 4;
        if (o_sready !== 1'b0) begin errors++; $display("FAIL bp_sready_full got %b want 0", o_sready); end
        if (o_fill !== 3'd4)   begin errors++; $display("FAIL bp_fill_full got %0d want 4", o_fill); end
        if (o_mvalid !== 1'b1) begin errors++; $display("FAIL bp_mvalid got %b want 1", o_mvalid); end
        if (o_mdata !== exp_win(0, 0)) begin errors++; $display("FAIL bp_win0 got %h want %h", o_mdata, exp_win(0, 0)); end
        held = exp_win(0, 0);
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b1);
            checks++;
            if (o_mvalid !== 1'b1 || o_mdata !== held) begin
                errors++; $display("FAIL bp_hold cycle %0d got v=%b %h want v=1 %h", i, o_mvalid, o_mdata, held);
            end
        end
        seen_intr = 1'b0; chk_sready = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick(1'b1, 1'b1);
            if (chk_sready) begin
                chk_sready = 1'b0; checks++;
                if (o_sready !== 1'b1) begin errors++; $display("FAIL bp_sready_after_release got %b want 1", o_sready); end
            end
            if (o_intr && !seen_intr) begin seen_intr = 1'b1; chk_sready = 1'b1; end
            if (o_wacc) begin
                checks++;
                if (o_mdata !== exp_win(win_rb, win_k)) begin
                    errors++; $display("FAIL bp_win rb%0d k%0d got %h want %h", win_rb, win_k, o_mdata, exp_win(win_rb, win_k));
                end
                adv_win(last);
            end
        end
        checks += 2;
        if (win_cnt != 12) begin errors++; $display("FAIL bp_count got %0d want 12", win_cnt); end
        if (intr_cnt != 2) begin errors++; $display("FAIL bp_intr_count got %0d want 2", intr_cnt); end
    endtask

    task automatic test_pad();
        bit last;
        apply_reset(1'b1);
        push_pattern(3);
        for (int t = 0; t < 60; t++) begin
            tick(1'b1, 1'b1);
            if (o_wacc) begin
                checks++;
                if (o_mdata !== exp_win(win_rb, win_k)) begin
                    errors++; $display("FAIL pad_win k%0d got %h want %h", win_k, o_mdata, exp_win(win_rb, win_k));
                end
                if (win_k == 0) begin
                    checks++;
                    for (int r = 0; r < K; r++)
                        if (o_mdata[(r*K)*PW +: PW] !== 8'h00) begin
                            errors++; $display("FAIL pad_left r%0d got %h want 00", r, o_mdata[(r*K)*PW +: PW]);
                        end
                end
                if (win_k == 7) begin
                    checks++;
                    for (int r = 0; r < K; r++)
                        if (o_mdata[(r*K+2)*PW +: PW] !== 8'h00) begin
                            errors++; $display("FAIL pad_right r%0d got %h want 00", r, o_mdata[(r*K+2)*PW +: PW]);
                        end
                end
                if (win_k == 3) begin
                    checks++;
                    if (o_mdata[4*PW +: PW] !== 8'h13) begin
                        errors++; $display("FAIL pad_centre got %h want 13", o_mdata[4*PW +: PW]);
                    end
                end
                adv_win(last);
            end
        end
        checks += 2;
        if (win_cnt != 8)  begin errors++; $display("FAIL pad_count got %0d want 8", win_cnt); end
        if (intr_cnt != 1) begin errors++; $display("FAIL pad_intr_count got %0d want 1", intr_cnt); end
    endtask

    task automatic test_simultaneous();
        bit last, seen_intr, chk_next;
        apply_reset(1'b0);
        push_pattern(3);
        for (int c = 0; c < W - 1; c++) pix_q.push_back(3 * 16 + c);
        seen_intr = 1'b0; chk_next = 1'b0;
        for (int t = 0; t < 80; t++) begin
            tick(1'b1, 1'b1);
            if (chk_next) begin
                chk_next = 1'b0; checks++;
                if (o_fill !== 3'd3) begin errors++; $display("FAIL sim_fill_after got %0d want 3", o_fill); end
            end
            if (o_intr && !seen_intr) begin
                seen_intr = 1'b1; chk_next = 1'b1; checks += 2;
                if (o_acc_in !== 1'b1) begin errors++; $display("FAIL sim_accept_on_release got %b want 1", o_acc_in); end
                if (o_fill !== 3'd3)   begin errors++; $display("FAIL sim_fill_at got %0d want 3", o_fill); end
            end
            if (o_wacc) begin
                checks++;
                if (o_mdata !== exp_win(win_rb, win_k)) begin
                    errors++; $display("FAIL sim_win rb%0d k%0d got %h want %h", win_rb, win_k, o_mdata, exp_win(win_rb, win_k));
                end
                adv_win(last);
                if (last && win_rb == 1) pix_q.push_back(3 * 16 + W - 1);
            end
        end
        checks += 2;
        if (win_cnt != 12) begin errors++; $display("FAIL sim_count got %0d want 12", win_cnt); end
        if (intr_cnt != 2) begin errors++; $display("FAIL sim_intr_count got %0d want 2", intr_cnt); end
    endtask

    task automatic test_reset_mid_row();
        bit last;
        int t;
        apply_reset(1'b0);
        for (int i = 0; i < W + 5; i++) pix_q.push_back(8'hF0 | (i & 15));
        t = 0;
        while (pix_q.size() > 0 && t < 50) begin tick(1'b1, 1'b1); t++; end
        apply_reset(1'b0);
        for (int i = 0; i < 3 * W; i++) pix_q.push_back(int'($urandom_range(0, 127)));
        for (int i = 0; i < 60; i++) begin
            tick(1'b1, 1'b1);
            if (o_wacc) begin
                checks++;
                if (o_mdata !== exp_win(win_rb, win_k)) begin
                    errors++; $display("FAIL mid_win rb%0d k%0d got %h want %h", win_rb, win_k, o_mdata, exp_win(win_rb, win_k));
                end
                adv_win(last);
            end
        end
        checks += 2;
        if (win_cnt != 6)  begin errors++; $display("FAIL mid_count got %0d want 6", win_cnt); end
        if (intr_cnt != 1) begin errors++; $display("FAIL mid_intr_count got %0d want 1", intr_cnt); end
    endtask

    task automatic test_random();
        bit last, exp_intr, stall;
        logic [WW-1:0] prev;
        int t;
        apply_reset(1'b0);
        for (int i = 0; i < 6 * W; i++) pix_q.push_back(int'($urandom_range(0, 255)));
        exp_intr = 1'b0; stall = 1'b0; prev = '0; t = 0;
        while (win_cnt < 24 && t < 3000) begin
            tick($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 70);
            t++;
            checks += 3;
            if (o_fill > 3'd4) begin errors++; $display("FAIL rnd_fill_bound got %0d want <=4", o_fill); end
            if (o_sready !== (o_fill < 3'd4)) begin
                errors++; $display("FAIL rnd_sready got %b want %b", o_sready, o_fill < 3'd4);
            end
            if (o_intr !== exp_intr) begin errors++; $display("FAIL rnd_intr got %b want %b", o_intr, exp_intr); end
            if (stall) begin
                checks++;
                if (o_mvalid !== 1'b1 || o_mdata !== prev) begin
                    errors++; $display("FAIL rnd_hold got v=%b %h want v=1 %h", o_mvalid, o_mdata, prev);
                end
            end
            stall = o_mvalid && !m_ready;
            prev  = o_mdata;
            exp_intr = 1'b0;
            if (o_wacc) begin
                checks++;
                if (o_mdata !== exp_win(win_rb, win_k)) begin
                    errors++; $display("FAIL rnd_win rb%0d k%0d got %h want %h", win_rb, win_k, o_mdata, exp_win(win_rb, win_k));
                end
                adv_win(last);
                exp_intr = last;
            end
        end
        repeat (5) tick(1'b1, 1'b1);
        checks += 3;
        if (win_cnt != 24) begin errors++; $display("FAIL rnd_count got %0d want 24", win_cnt); end
        if (intr_cnt != 4) begin errors++; $display("FAIL rnd_intr_count got %0d want 4", intr_cnt); end
        if (o_fill !== 3'd2) begin errors++; $display("FAIL rnd_final_fill got %0d want 2", o_fill); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_pad();
        test_simultaneous();
        test_reset_mid_row();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
